// File: rtl/multicycle_controller_if.sv
// Datapath-facing bundle of the multicycle controller: opcode/memory handshake in,
// mux selects and enables out.
interface multicycle_controller_if;
  logic [5:0] instruction;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, aluSrcA, regWrite, regDst;
  logic [1:0] pcSource, aluSrcB, aluOp, branch;
  logic       illegalOp, fault;
  logic [3:0] state;

  modport master (
    input  instruction, memReady,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, aluSrcA,
           regWrite, regDst, pcSource, aluSrcB, aluOp, branch, illegalOp, fault, state
  );

  modport slave (
    output instruction, memReady,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, aluSrcA,
           regWrite, regDst, pcSource, aluSrcB, aluOp, branch, illegalOp, fault, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS main control FSM with memory-ready watchdog and sticky fault.
// Define MC_BNE_EN to decode BNE (opcode 000101) through the BRANCH state.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input logic                      clock,
  input logic                      reset,
  multicycle_controller_if.master  bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11,
    StFault    = 4'd15
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  state_e             stateQ, stateD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic               waitSt, timedOut;

  assign waitSt   = (stateQ == StFetch) || (stateQ == StMemRead) || (stateQ == StMemWrite);
  // A ready memory in the timeout cycle still completes the access.
  assign timedOut = (TIMEOUT != 0) && (cntQ == CNT_W'(TIMEOUT)) && !bus.memReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= StFetch;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  always_comb begin
    stateD          = stateQ;
    bus.pcWrite     = 1'b0;
    bus.pcWriteCond = 1'b0;
    bus.iorD        = 1'b0;
    bus.memRead     = 1'b0;
    bus.memWrite    = 1'b0;
    bus.irWrite     = 1'b0;
    bus.memToReg    = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.regWrite    = 1'b0;
    bus.regDst      = 1'b0;
    bus.pcSource    = 2'b00;
    bus.aluSrcB     = 2'b00;
    bus.aluOp       = 2'b00;
    bus.branch      = 2'b00;
    bus.illegalOp   = 1'b0;
    bus.fault       = 1'b0;
    bus.state       = 4'd0;

    unique case (stateQ)
      StFetch: begin
        bus.memRead = 1'b1;
        bus.aluSrcB = 2'b01;
        bus.irWrite = bus.memReady;
        bus.pcWrite = bus.memReady;
        if (bus.memReady) stateD = StDecode;
        else if (timedOut) stateD = StFault;
      end
      StDecode: begin
        bus.aluSrcB = 2'b11;
        case (bus.instruction)
          OpRType:    stateD = StExecute;
          OpLw, OpSw: stateD = StMemAddr;
          OpBeq:      stateD = StBranch;
`ifdef MC_BNE_EN
          OpBne:      stateD = StBranch;
`endif
          OpJ:        stateD = StJump;
          OpAddi:     stateD = StAddiExec;
          default: begin
            bus.illegalOp = 1'b1;
            stateD        = StFetch;
          end
        endcase
      end
      StMemAddr: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        stateD      = (bus.instruction == OpLw) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        bus.memRead = 1'b1;
        bus.iorD    = 1'b1;
        if (bus.memReady) stateD = StMemWb;
        else if (timedOut) stateD = StFault;
      end
      StMemWb: begin
        bus.memToReg = 1'b1;
        bus.regWrite = 1'b1;
        stateD       = StFetch;
      end
      StMemWrite: begin
        bus.memWrite = 1'b1;
        bus.iorD     = 1'b1;
        if (bus.memReady) stateD = StFetch;
        else if (timedOut) stateD = StFault;
      end
      StExecute: begin
        bus.aluSrcA = 1'b1;
        bus.aluOp   = 2'b10;
        stateD      = StAluWb;
      end
      StAluWb: begin
        bus.regDst   = 1'b1;
        bus.regWrite = 1'b1;
        stateD       = StFetch;
      end
      StBranch: begin
        bus.aluSrcA     = 1'b1;
        bus.aluOp       = 2'b01;
        bus.pcWriteCond = 1'b1;
        bus.pcSource    = 2'b01;
        bus.branch      = 2'b01;
`ifdef MC_BNE_EN
        if (bus.instruction == OpBne) bus.branch = 2'b10;
`endif
        stateD = StFetch;
      end
      StJump: begin
        bus.pcWrite  = 1'b1;
        bus.pcSource = 2'b10;
        stateD       = StFetch;
      end
      StAddiExec: begin
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
        stateD      = StAddiWb;
      end
      StAddiWb: begin
        bus.regWrite = 1'b1;
        stateD       = StFetch;
      end
      StFault: begin
        bus.fault = 1'b1;
      end
      default: stateD = StFault;
    endcase

    bus.state = stateQ;

    // Wait counter restarts on every state change, so entering a wait state sees zero.
    if (stateD != stateQ) cntD = '0;
    else if (waitSt && !bus.memReady) cntD = cntQ + 1'b1;
    else cntD = cntQ;

    // Async reset must drop every enable immediately, not at the next edge.
    if (reset) begin
      bus.pcWrite     = 1'b0;
      bus.pcWriteCond = 1'b0;
      bus.iorD        = 1'b0;
      bus.memRead     = 1'b0;
      bus.memWrite    = 1'b0;
      bus.irWrite     = 1'b0;
      bus.memToReg    = 1'b0;
      bus.aluSrcA     = 1'b0;
      bus.regWrite    = 1'b0;
      bus.regDst      = 1'b0;
      bus.pcSource    = 2'b00;
      bus.aluSrcB     = 2'b00;
      bus.aluOp       = 2'b00;
      bus.branch      = 2'b00;
      bus.illegalOp   = 1'b0;
      bus.fault       = 1'b0;
      bus.state       = 4'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against per-instruction expected state/control traces.
module tb_multicycle_controller;
  localparam int unsigned Timeout = 16;
`ifdef MC_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  multicycle_controller_if m ();

  multicycle_controller #(.TIMEOUT(Timeout), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (m.master)
  );

  always #5 clock = ~clock;

  logic [19:0] got;
  assign got = {m.pcWrite, m.pcWriteCond, m.iorD, m.memRead, m.memWrite, m.irWrite,
                m.memToReg, m.aluSrcA, m.regWrite, m.regDst, m.pcSource, m.aluSrcB,
                m.aluOp, m.branch, m.illegalOp, m.fault};

  logic [3:0] plan_st[$];
  bit         plan_rdy[$];

  function automatic bit legal(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 ||
           op == 6'b000010 || op == 6'b001000 || (BneEn && op == 6'b000101);
  endfunction

  // Control word expected in a given state, straight from the state table.
  function automatic logic [19:0] exp_ctrl(input int st, input bit rdy, input logic [5:0] op);
    logic pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, ill, flt;
    logic [1:0] ps, asb, aop, br;
    {pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, ill, flt} = '0;
    {ps, asb, aop, br} = '0;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:  begin asb = 2'b11; ill = !legal(op); end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iod = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin
            asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01;
            br = (BneEn && op == 6'b000101) ? 2'b10 : 2'b01;
          end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      15: flt = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, asa, rw, rd, ps, asb, aop, br, ill, flt};
  endfunction

  task automatic push(input int st, input bit rdy);
    plan_st.push_back(4'(st));
    plan_rdy.push_back(rdy);
  endtask

  // Expected per-cycle state trace of one instruction with the given wait counts.
  task automatic build_plan(input logic [5:0] op, input int wf, input int wm);
    plan_st.delete();
    plan_rdy.delete();
    repeat (wf) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'($urandom()));
    case (op)
      6'b000000: begin push(6, 1'($urandom())); push(7, 1'($urandom())); end
      6'b001000: begin push(10, 1'($urandom())); push(11, 1'($urandom())); end
      6'b100011: begin
        push(2, 1'($urandom()));
        repeat (wm) push(3, 1'b0);
        push(3, 1'b1);
        push(4, 1'($urandom()));
      end
      6'b101011: begin
        push(2, 1'($urandom()));
        repeat (wm) push(5, 1'b0);
        push(5, 1'b1);
      end
      6'b000100: push(8, 1'($urandom()));
      6'b000101: if (BneEn) push(8, 1'($urandom()));
      6'b000010: push(9, 1'($urandom()));
      default: ;
    endcase
  endtask

  // Leaves the bench at a falling edge with reset just released (first FETCH cycle).
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    m.memReady = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    m.memReady = 1'b1;
    m.instruction = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (got !== 20'd0 || m.state !== 4'd0) begin
        bad++;
        $display("FAIL reset_hold: ctrl=%h state=%0d, required ctrl=0 state=0", got, m.state);
      end
      @(negedge clock);
    end
    reset = 1'b0;
    #1;
    total++;
    if (m.state !== 4'd0 || got !== exp_ctrl(0, 1'b1, 6'b0)) begin
      bad++;
      $display("FAIL reset_release: ctrl=%h state=%0d, required ctrl=%h state=0",
               got, m.state, exp_ctrl(0, 1'b1, 6'b0));
    end
    @(negedge clock);
  endtask

  task automatic test_lw();
    int exp_st[6] = '{0, 1, 2, 3, 4, 0};
    do_reset();
    m.memReady = 1'b1;
    m.instruction = 6'b100011;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (m.state !== 4'(exp_st[i]) || m.regWrite !== (exp_st[i] == 4) ||
          m.memToReg !== (exp_st[i] == 4)) begin
        bad++;
        $display("FAIL lw_step%0d: state=%0d regWrite=%b memToReg=%b, required state=%0d",
                 i, m.state, m.regWrite, m.memToReg, exp_st[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_sw_wait();
    int exp_st[8] = '{0, 1, 2, 5, 5, 5, 5, 0};
    bit rdy[8]    = '{1, 1, 1, 0, 0, 0, 1, 1};
    int writes = 0;
    do_reset();
    m.instruction = 6'b101011;
    for (int i = 0; i < 8; i++) begin
      m.memReady = rdy[i];
      #1;
      if (m.memWrite === 1'b1) writes++;
      total++;
      if (m.state !== 4'(exp_st[i]) || m.fault !== 1'b0) begin
        bad++;
        $display("FAIL sw_step%0d: state=%0d fault=%b, required state=%0d fault=0",
                 i, m.state, m.fault, exp_st[i]);
      end
      @(negedge clock);
    end
    total++;
    if (writes != 4) begin
      bad++;
      $display("FAIL sw_write_cycles: got %0d, required 4", writes);
    end
  endtask

  task automatic test_illegal();
    int pulses = 0;
    int exp_st[3] = '{0, 1, 0};
    do_reset();
    m.memReady = 1'b1;
    m.instruction = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (m.illegalOp === 1'b1) pulses++;
      total++;
      if (m.state !== 4'(exp_st[i]) || (i == 1 && (m.regWrite | m.memWrite | m.pcWrite |
          m.pcWriteCond | m.irWrite) !== 1'b0)) begin
        bad++;
        $display("FAIL illegal_step%0d: state=%0d ctrl=%h, required state=%0d no enables",
                 i, m.state, got, exp_st[i]);
      end
      @(negedge clock);
    end
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL illegal_pulse: got %0d cycles, required 1", pulses);
    end
  endtask

  task automatic test_bne();
    int exp_st[$];
    exp_st = BneEn ? '{0, 1, 8, 0} : '{0, 1, 0};
    do_reset();
    m.memReady = 1'b1;
    m.instruction = 6'b000101;
    foreach (exp_st[i]) begin
      #1;
      total++;
      if (m.state !== 4'(exp_st[i]) || got !== exp_ctrl(exp_st[i], 1'b1, 6'b000101)) begin
        bad++;
        $display("FAIL bne_step%0d: state=%0d ctrl=%h, required state=%0d ctrl=%h", i,
                 m.state, got, exp_st[i], exp_ctrl(exp_st[i], 1'b1, 6'b000101));
      end
      @(negedge clock);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    m.memReady = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (m.state !== 4'd0) break;
      n++;
      @(negedge clock);
    end
    total++;
    if (n != Timeout + 1 || m.state !== 4'd15 || m.fault !== 1'b1) begin
      bad++;
      $display("FAIL timeout_fetch: %0d cycles state=%0d fault=%b, required %0d state=15 fault=1",
               n, m.state, m.fault, Timeout + 1);
    end
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      m.memReady = 1'($urandom());
      #1;
      total++;
      if (m.state !== 4'd15 || got !== exp_ctrl(15, 1'b0, 6'b0)) begin
        bad++;
        $display("FAIL fault_sticky%0d: state=%0d ctrl=%h, required state=15 ctrl=%h",
                 i, m.state, got, exp_ctrl(15, 1'b0, 6'b0));
      end
      @(negedge clock);
    end
    do_reset();
    m.instruction = 6'b000010;
    for (int k = 0; k <= Timeout; k++) begin
      m.memReady = (k == Timeout);
      #1;
      total++;
      if (m.state !== 4'd0 || got !== exp_ctrl(0, m.memReady, 6'b0)) begin
        bad++;
        $display("FAIL timeout_edge%0d: state=%0d ctrl=%h, required state=0", k, m.state, got);
      end
      @(negedge clock);
    end
    #1;
    total++;
    if (m.state !== 4'd1) begin
      bad++;
      $display("FAIL timeout_ready_wins: state=%0d, required 1", m.state);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int exp_st[4] = '{0, 1, 2, 5};
    do_reset();
    m.memReady = 1'b1;
    m.instruction = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      m.memReady = (i < 3);
      #1;
      total++;
      if (m.state !== 4'(exp_st[i])) begin
        bad++;
        $display("FAIL mid_path%0d: state=%0d, required %0d", i, m.state, exp_st[i]);
      end
      if (i < 3) @(negedge clock);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (got !== 20'd0 || m.state !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid: ctrl=%h state=%0d, required ctrl=0 state=0", got, m.state);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] ops[8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                           6'b000010, 6'b001000, 6'b000101, 6'b111111};
    logic [5:0] op;
    logic [3:0] st;
    bit         rdy;
    int         idx;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 8);
      op  = (idx == 8) ? 6'($urandom()) : ops[idx];
      build_plan(op, $urandom_range(0, 3), $urandom_range(0, 4));
      while (plan_st.size() > 0) begin
        st  = plan_st.pop_front();
        rdy = plan_rdy.pop_front();
        m.instruction = op;
        m.memReady    = rdy;
        #1;
        total++;
        if (m.state !== st || got !== exp_ctrl(int'(st), rdy, op)) begin
          bad++;
          $display("FAIL rand_op%b: state=%0d ctrl=%h, required state=%0d ctrl=%h", op,
                   m.state, got, st, exp_ctrl(int'(st), rdy, op));
        end
        @(negedge clock);
      end
    end
    #1;
    total++;
    if (m.state !== 4'd0) begin
      bad++;
      $display("FAIL rand_end: state=%0d, required 0", m.state);
    end
  endtask

  initial begin
    m.instruction = 6'b0;
    m.memReady    = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_illegal();
    test_bne();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
